// File: rtl/hack_screen_pkg.sv
// Shared constants and the state encoding for the Hack screen read-side master.
// The screen is 512x256 pixels at 1 bit per pixel, stored as 8K 16-bit words in row-major order.
package hack_screen_pkg;

  localparam int SCREEN_WORDS    = 8192;
  localparam int WORDS_PER_ROW   = 32;
  localparam int PIXELS_PER_WORD = 16;
  // This is the CPU-side base address. The RAM port seen by this block starts at BASE_ADDR.
  localparam int SCREEN_BASE     = 16384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/screen_word_counter.sv
// Word index for the screen walk: holds the running count, builds the RAM address from it,
// and raises the end-of-row and end-of-frame flags.
module screen_word_counter
  import hack_screen_pkg::*;
#(
  parameter int ADDR_WIDTH    = 13,
  parameter int WORDS_PER_ROW = hack_screen_pkg::WORDS_PER_ROW,
  parameter int NUM_WORDS     = SCREEN_WORDS,
  parameter int BASE_ADDR     = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  clr,
  input  logic                  inc,
  output logic                  lastInRow,
  output logic                  lastInFrame,
  output logic [ADDR_WIDTH-1:0] address
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   r_idx <= '0;
    else if (clr) r_idx <= '0;
    else if (inc) r_idx <= r_idx + 1'b1;
  end

  assign lastInFrame = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign lastInRow   = ((r_idx % IDX_W'(WORDS_PER_ROW)) == IDX_W'(WORDS_PER_ROW - 1));
  // Adding the base can carry past ADDR_WIDTH bits. The carry is dropped, so the address wraps.
  assign address     = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_idx);

endmodule

// File: rtl/screen_reader.sv
// Walks the screen RAM word by word and serializes each word into a valid/ready pixel
// stream with row and frame markers. One FETCH bubble is spent per word.
module screen_reader
  import hack_screen_pkg::*;
#(
  parameter int DATA_WIDTH    = PIXELS_PER_WORD,
  parameter int ADDR_WIDTH    = 13,
  parameter int WORDS_PER_ROW = hack_screen_pkg::WORDS_PER_ROW,
  parameter int NUM_WORDS     = SCREEN_WORDS,
  parameter int BASE_ADDR     = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  continuous,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] ramData,
  output logic                  pixel,
  output logic                  pixelValid,
  input  logic                  pixelReady,
  output logic                  lineEnd,
  output logic                  frameEnd,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]      r_bit;
  logic                  w_clr, w_inc, w_load, w_bit_inc;
  logic                  w_last_bit, w_last_row, w_last_frame, w_shift;

  screen_word_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .WORDS_PER_ROW(WORDS_PER_ROW),
    .NUM_WORDS    (NUM_WORDS),
    .BASE_ADDR    (BASE_ADDR)
  ) u_cnt (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr        (w_clr),
    .inc        (w_inc),
    .lastInRow  (w_last_row),
    .lastInFrame(w_last_frame),
    .address    (address)
  );

  assign w_shift    = (r_state == SHIFT);
  assign w_last_bit = (r_bit == BIT_W'(DATA_WIDTH - 1));

  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    w_load    = 1'b0;
    w_bit_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = FETCH;
          w_clr  = 1'b1;
        end
      end
      FETCH: begin
        w_load = 1'b1;
        w_next = SHIFT;
      end
      SHIFT: begin
        if (pixelReady) begin
          if (!w_last_bit) begin
            w_bit_inc = 1'b1;
          end else if (!w_last_frame) begin
            w_inc  = 1'b1;
            w_next = FETCH;
          end else begin
            // On the final pixel, start is ignored. Only continuous decides whether the next frame begins.
            w_clr  = 1'b1;
            w_next = continuous ? FETCH : IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_shift <= ramData;
        r_bit   <= '0;
      end else if (w_bit_inc) begin
        r_bit <= r_bit + 1'b1;
      end
    end
  end

  // The LSB of the word is the leftmost pixel on screen.
  assign pixel      = w_shift & r_shift[r_bit];
  assign pixelValid = w_shift;
  assign lineEnd    = w_shift & w_last_bit & w_last_row;
  assign frameEnd   = w_shift & w_last_bit & w_last_frame;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_screen_reader.sv
// Directed bench for screen_reader, built with a 256-word frame (8 rows of 512 pixels)
// so that several full frames complete quickly.
module tb_screen_reader;

  localparam int DW  = 16;
  localparam int AW  = 13;
  localparam int NW  = 256;
  localparam int WPR = 32;
  localparam int PIX = NW * DW;
  localparam int ROW = WPR * DW;

  logic          CLK = 1'b0;
  logic          RST_N, start, continuous, pixelReady;
  logic [AW-1:0] address;
  logic [DW-1:0] ramData;
  logic          pixel, pixelValid, lineEnd, frameEnd, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int acc, lines, first_line, frames, frame_pix, pix_err, le_err;

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    case (a)
      13'd0:   return 16'h0001;
      13'd1:   return 16'h8000;
      13'd5:   return 16'hA5A5;
      default: return {a[7:0] ^ 8'h3C, ~a[7:0]};
    endcase
  endfunction

  assign ramData = ram_word(address);

  screen_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS_PER_ROW(WPR), .NUM_WORDS(NW), .BASE_ADDR(0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .continuous(continuous),
    .address(address), .ramData(ramData), .pixel(pixel), .pixelValid(pixelValid),
    .pixelReady(pixelReady), .lineEnd(lineEnd), .frameEnd(frameEnd), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    #3;
    RST_N = 1'b1;
    tick;
  endtask

  // Accept pixels with the bench's own model of the expected stream until frameEnd is taken.
  task automatic run_frame(input int budget, input int pulse_at, output bit done);
    logic [DW-1:0] w;
    int idx;
    acc = 0; lines = 0; first_line = -1; frames = 0; frame_pix = -1; pix_err = 0; le_err = 0;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      if (pixelValid && pixelReady) begin
        idx = acc;
        w = ram_word(AW'(idx / DW));
        if (pixel !== w[idx % DW]) pix_err++;
        if (lineEnd !== (((idx + 1) % ROW) == 0)) le_err++;
        if (lineEnd) begin
          lines++;
          if (first_line < 0) first_line = idx + 1;
        end
        if (frameEnd) begin
          frames++;
          frame_pix = idx + 1;
          done = 1'b1;
        end
        acc++;
      end
      start = (c == pulse_at);
      tick;
    end
    start = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w0, w1, got;
    logic [AW-1:0] a_hold;
    logic          p_hold, le_hold, ok_all;
    int            bad, k, stalls, stall_err, cnt;
    bit            done, found;

    RST_N = 1'b0; start = 1'b0; continuous = 1'b0; pixelReady = 1'b1;
    #12;
    chk("rst_addr", address, 0);
    chk("rst_valid", pixelValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_marks", {pixel, lineEnd, frameEnd}, 0);
    #2 RST_N = 1'b1;
    tick;

    // Idle with start held low
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (address !== 0 || pixelValid !== 1'b0 || busy !== 1'b0) bad++;
      tick;
    end
    chk("idle_20", bad, 0);

    // First two words, with a FETCH bubble between them
    start = 1'b1; tick; start = 1'b0;
    chk("fetch0_valid", pixelValid, 0);
    chk("fetch0_busy", busy, 1);
    chk("fetch0_addr", address, 0);
    tick;
    ok_all = 1'b1;
    for (int i = 0; i < DW; i++) begin w0[i] = pixel; ok_all &= pixelValid; tick; end
    chk("bubble_valid", pixelValid, 0);
    chk("bubble_addr", address, 1);
    tick;
    for (int i = 0; i < DW; i++) begin w1[i] = pixel; ok_all &= pixelValid; tick; end
    chk("word0", w0, 16'h0001);
    chk("word1", w1, 16'h8000);
    chk("words_valid", ok_all, 1);
    do_reset;

    // Full frame with the consumer always ready
    start = 1'b1; tick; start = 1'b0;
    run_frame(6000, -1, done);
    chk("frame_done", done, 1);
    chk("frame_pixels", acc, PIX);
    chk("frame_lines", lines, NW / WPR);
    chk("first_line", first_line, ROW);
    chk("frame_ends", frames, 1);
    chk("frame_end_pix", frame_pix, PIX);
    chk("frame_pix_err", pix_err, 0);
    chk("frame_le_err", le_err, 0);
    chk("busy_fall", busy, 0);
    chk("idle_valid", pixelValid, 0);

    // Random back-pressure while word 5 (16'hA5A5) is being serialized
    start = 1'b1; tick; start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (pixelValid && address == 5) found = 1'b1;
      else tick;
    end
    chk("reach_w5", found, 1);
    k = 0; stalls = 0; stall_err = 0; got = '0;
    for (int c = 0; c < 300 && k < DW; c++) begin
      pixelReady = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      p_hold = pixel; le_hold = lineEnd; a_hold = address;
      if (pixelValid && pixelReady) begin
        if (address !== 5) stall_err++;
        got[k] = pixel;
        k++;
        tick;
      end else begin
        stalls++;
        tick;
        if (pixel !== p_hold || lineEnd !== le_hold || address !== a_hold || pixelValid !== 1'b1)
          stall_err++;
      end
    end
    pixelReady = 1'b1;
    chk("w5_count", k, DW);
    chk("w5_seq", got, 16'hA5A5);
    chk("w5_stall_hold", stall_err, 0);
    chk("w5_stalled", stalls > 0, 1);
    chk("w5_next_fetch", {pixelValid, address}, {1'b0, 13'd6});
    do_reset;

    // Continuous mode, with a start pulse injected mid-frame
    continuous = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    run_frame(6000, 200, done);
    chk("cont_done", done, 1);
    chk("cont_pixels", acc, PIX);
    chk("cont_pix_err", pix_err, 0);
    chk("cont_fetch", {busy, pixelValid, address}, {1'b1, 1'b0, 13'd0});
    tick;
    chk("cont_shift", {busy, pixelValid}, 2'b11);
    continuous = 1'b0;

    // Reset in the middle of word 100, at bit 7
    found = 1'b0; cnt = 0;
    for (int c = 0; c < 3000 && !found; c++) begin
      if (pixelValid && address == 100 && cnt == 7) found = 1'b1;
      else begin
        if (pixelValid && pixelReady && address == 100) cnt++;
        tick;
      end
    end
    chk("reach_w100", found, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_outs", {busy, pixelValid, pixel, lineEnd, frameEnd}, 0);
    chk("mid_rst_addr", address, 0);
    #3 RST_N = 1'b1;
    tick;
    chk("post_rst_idle", busy, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("fresh_addr", {pixelValid, address}, 0);
    tick;
    for (int i = 0; i < DW; i++) begin w0[i] = pixel; tick; end
    chk("fresh_word0", w0, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
